ipl_copy_master: RTL and testbench
==================================

IPL_COPY_MASTER -- requirements
Module: ipl_copy_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, Avalon-MM byte address width.
REQ-002 SHALL have parameter CNT_W, default 16, transfer word-count width.
REQ-003 SHALL have port clk  in  1  single clock; all logic rising-edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port start  in  1  one-cycle command strobe.
REQ-006 SHALL have port src_addr  in  ADDR_W  source byte address, word-aligned.
REQ-007 SHALL have port dst_addr  in  ADDR_W  destination byte address, word-aligned.
REQ-008 SHALL have port word_count  in  CNT_W  number of 32-bit words to copy.
REQ-009 SHALL have port busy  out  1  high while a copy is in progress.
REQ-010 SHALL have port done  out  1  one-cycle pulse at copy completion.
REQ-011 SHALL have port m_address  out  ADDR_W  Avalon-MM master address.
REQ-012 SHALL have ports m_read and m_write  out  1 each  Avalon-MM commands.
REQ-013 SHALL have port m_writedata  out  32  write data.
REQ-014 SHALL have port m_byteenable  out  4  byte enables, always 4'b1111.
REQ-015 SHALL have port m_readdata  in  32  read data.
REQ-016 SHALL have port m_readdatavalid  in  1  read data qualifier.
REQ-017 SHALL have port m_waitrequest  in  1  slave stall.

Function
REQ-018 SHALL implement FSM states IDLE, RD_REQ, RD_WAIT, WR_REQ, FINISH.
REQ-019 SHALL, in IDLE with start=1 and word_count>0: latch src/dst/count, assert busy, go to RD_REQ next cycle.
REQ-020 SHALL, in IDLE with start=1 and word_count=0: go to FINISH with no bus transaction.
REQ-021 SHALL ignore start whenever not in IDLE.
REQ-022 SHALL, in RD_REQ: drive m_read=1, m_address=current src; hold both stable while m_waitrequest=1; go to RD_WAIT on the first cycle m_waitrequest=0.
REQ-023 SHALL accept m_readdatavalid in the same cycle the read is accepted (zero-latency slave) and in any later cycle; capture m_readdata into a 32-bit holding register; then go to WR_REQ.
REQ-024 SHALL have at most one read outstanding; m_readdatavalid outside RD_REQ/RD_WAIT SHALL be ignored.
REQ-025 SHALL, in WR_REQ: drive m_write=1, m_address=current dst, m_writedata=holding register; hold stable while m_waitrequest=1.
REQ-026 SHALL, on write acceptance: src+=4, dst+=4, remaining-=1; go to RD_REQ if remaining≠0 after decrement, else FINISH.
REQ-027 SHALL wrap address increments modulo 2^ADDR_W without error.
REQ-028 SHALL never assert m_read and m_write in the same cycle.
REQ-029 SHALL, in FINISH: pulse done=1 for exactly one cycle, drop busy in that cycle, return to IDLE.
REQ-030 SHALL keep busy=1 from the cycle after start through the last WR_REQ cycle.
REQ-031 SHALL accept a new start in the cycle after FINISH.
REQ-032 SHALL, for word_count=N with zero wait states and zero read latency, complete in 2N+2 cycles from start to done.

Reset
REQ-033 SHALL on reset_n=0 immediately force: state IDLE, busy=0, done=0, m_read=0, m_write=0, m_address=0, m_writedata=0, counters 0.
REQ-034 SHALL abort any copy on reset mid-operation; no further bus commands until a new start.
REQ-035 SHALL release reset synchronously to clk externally; the block itself SHALL NOT re-synchronize reset_n.

Structure
REQ-036 SHALL place FSM state encoding and the word stride constant (4) in shared package ipl_copy_pkg.
REQ-037 SHALL be a single flat module; no sub-module.
REQ-038 SHALL register all Avalon-MM outputs (no combinational input-to-output paths).

Verification
REQ-039 SHALL cover: src=0x0000, dst=0x1000, count=4, no waits, 0-latency -> 4 reads then 4 writes interleaved, done at cycle 10, dst memory equals src.
REQ-040 SHALL cover: count=0 -> no m_read/m_write, done pulses 2 cycles after start.
REQ-041 SHALL cover: m_waitrequest random 0-3 cycles per command, readdatavalid delayed 2 cycles -> addresses/data held stable while stalled, final contents correct.
REQ-042 SHALL cover: start pulsed while busy -> ignored, copy of original count completes, single done.
REQ-043 SHALL cover: reset_n low during third WR_REQ -> all outputs 0 same cycle; after release, new start count=2 works normally.
REQ-044 SHALL cover: src=0xFFFFFFF8, count=3 -> third read address 0x00000000 (wrap).

Source files
------------

// File: rtl/ipl_copy_pkg.sv
// Shared definitions for the IPL copy master: FSM encoding and bus word stride.
package ipl_copy_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_REQ  = 3'd1,
      RD_WAIT = 3'd2,
      WR_REQ  = 3'd3,
      FINISH  = 3'd4
   } ipl_state_t;

   // Every transfer moves one 32-bit word, so addresses advance by 4 bytes.
   localparam int unsigned WORD_STRIDE = 4;

endpackage

// File: rtl/ipl_copy_master.sv
// Avalon-MM word copy engine: reads word_count words from src_addr and writes
// them to dst_addr one at a time, with a single read outstanding.
module ipl_copy_master
   import ipl_copy_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [CNT_W-1:0]  word_count,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] m_address,
   output logic              m_read,
   output logic              m_write,
   output logic [31:0]       m_writedata,
   output logic [3:0]        m_byteenable,
   input  logic [31:0]       m_readdata,
   input  logic              m_readdatavalid,
   input  logic              m_waitrequest,
   output logic [2:0]        dbg_state
);

   // Handshake: a command (m_read or m_write) is accepted on a rising edge where
   // it is high and m_waitrequest is low; until then address, command and data
   // stay frozen. Read data is taken only on a cycle with m_readdatavalid high,
   // either the accepting cycle itself or any later one.

   ipl_state_t        state_q;
   logic [ADDR_W-1:0] src_q;
   logic [ADDR_W-1:0] dst_q;
   logic [CNT_W-1:0]  rem_q;
   logic [ADDR_W-1:0] src_next;
   logic [ADDR_W-1:0] dst_next;

   assign src_next     = src_q + ADDR_W'(WORD_STRIDE);
   assign dst_next     = dst_q + ADDR_W'(WORD_STRIDE);
   assign m_byteenable = 4'b1111;
   assign dbg_state    = state_q;

   // m_writedata doubles as the read-data holding register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         src_q       <= '0;
         dst_q       <= '0;
         rem_q       <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         m_read      <= 1'b0;
         m_write     <= 1'b0;
         m_address   <= '0;
         m_writedata <= '0;
      end else begin
         done <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  if (word_count != '0) begin
                     src_q     <= src_addr;
                     dst_q     <= dst_addr;
                     rem_q     <= word_count;
                     busy      <= 1'b1;
                     m_read    <= 1'b1;
                     m_address <= src_addr;
                     state_q   <= RD_REQ;
                  end else begin
                     state_q <= FINISH;
                  end
               end
            end
            RD_REQ: begin
               if (!m_waitrequest) begin
                  m_read <= 1'b0;
                  if (m_readdatavalid) begin
                     m_writedata <= m_readdata;
                     m_write     <= 1'b1;
                     m_address   <= dst_q;
                     state_q     <= WR_REQ;
                  end else begin
                     state_q <= RD_WAIT;
                  end
               end
            end
            RD_WAIT: begin
               if (m_readdatavalid) begin
                  m_writedata <= m_readdata;
                  m_write     <= 1'b1;
                  m_address   <= dst_q;
                  state_q     <= WR_REQ;
               end
            end
            WR_REQ: begin
               if (!m_waitrequest) begin
                  m_write <= 1'b0;
                  src_q   <= src_next;
                  dst_q   <= dst_next;
                  rem_q   <= rem_q - CNT_W'(1);
                  if (rem_q != CNT_W'(1)) begin
                     m_read    <= 1'b1;
                     m_address <= src_next;
                     state_q   <= RD_REQ;
                  end else begin
                     state_q <= FINISH;
                  end
               end
            end
            FINISH: begin
               done    <= 1'b1;
               busy    <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ipl_copy_master.sv
// Bench for ipl_copy_master: Avalon slave memory model with random stalls and
// read latency, plus a queue-based scoreboard of expected reads and writes.
module tb_ipl_copy_master;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [31:0] src_addr;
   logic [31:0] dst_addr;
   logic [15:0] word_count;
   logic        busy;
   logic        done;
   logic [31:0] m_address;
   logic        m_read;
   logic        m_write;
   logic [31:0] m_writedata;
   logic [3:0]  m_byteenable;
   logic [31:0] m_readdata;
   logic        m_readdatavalid;
   logic        m_waitrequest;
   logic [2:0]  dbg_state;

   ipl_copy_master #(.ADDR_W(32), .CNT_W(16)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .start           (start),
      .src_addr        (src_addr),
      .dst_addr        (dst_addr),
      .word_count      (word_count),
      .busy            (busy),
      .done            (done),
      .m_address       (m_address),
      .m_read          (m_read),
      .m_write         (m_write),
      .m_writedata     (m_writedata),
      .m_byteenable    (m_byteenable),
      .m_readdata      (m_readdata),
      .m_readdatavalid (m_readdatavalid),
      .m_waitrequest   (m_waitrequest),
      .dbg_state       (dbg_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL global_timeout: got no end, expected $finish");
      $fatal(1, "bench timeout");
   end

   // scoreboard state
   logic [63:0] exp_q[$];     // {address, data} of each expected write
   logic [31:0] exp_rd_q[$];  // expected read addresses
   logic [31:0] mem [logic [31:0]];
   int n_checks = 0;
   int n_pass   = 0;
   int max_wait = 0;
   int lat      = 0;
   int wr_acc   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [31:0] rd_word(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return a ^ 32'hA5A5_5A5A;
   endfunction

   // Avalon slave model, evaluated on the falling edge while DUT outputs are stable.
   initial begin : slave
      int          wait_left;
      int          pend;
      bit          in_cmd;
      bit          prev_stall;
      logic [1:0]  prev_cmd;
      logic [31:0] prev_addr;
      logic [31:0] prev_data;
      logic [31:0] pend_addr;
      logic [63:0] e;
      m_waitrequest   = 1'b0;
      m_readdatavalid = 1'b0;
      m_readdata      = '0;
      wait_left = 0; pend = 0; in_cmd = 0; prev_stall = 0;
      prev_cmd = '0; prev_addr = '0; prev_data = '0; pend_addr = '0;
      forever begin
         @(negedge clk);
         m_readdatavalid = 1'b0;
         m_readdata      = $urandom;
         if (!reset_n) begin
            in_cmd = 0; pend = 0; prev_stall = 0; wait_left = 0;
            m_waitrequest = 1'b0;
            continue;
         end
         if (prev_stall) begin
            check("hold_cmd", {m_read, m_write}, prev_cmd);
            check("hold_addr", m_address, prev_addr);
            if (m_write) check("hold_data", m_writedata, prev_data);
         end
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               m_readdatavalid = 1'b1;
               m_readdata      = rd_word(pend_addr);
            end
         end
         if (m_read || m_write) begin
            check("rd_wr_exclusive", m_read & m_write, 1'b0);
            if (!in_cmd) begin
               in_cmd    = 1;
               wait_left = $urandom_range(0, max_wait);
            end
            if (wait_left > 0) begin
               wait_left--;
               m_waitrequest = 1'b1;
               prev_stall = 1;
               prev_cmd   = {m_read, m_write};
               prev_addr  = m_address;
               prev_data  = m_writedata;
            end else begin
               m_waitrequest = 1'b0;
               prev_stall = 0;
               in_cmd     = 0;
               if (m_read) begin
                  if (exp_rd_q.size() == 0) check("rd_unexpected", m_address, 64'hFFFF_FFFF_FFFF_FFFF);
                  else check("rd_addr", m_address, exp_rd_q.pop_front());
                  if (lat == 0) begin
                     m_readdatavalid = 1'b1;
                     m_readdata      = rd_word(m_address);
                  end else begin
                     pend      = lat;
                     pend_addr = m_address;
                  end
               end else begin
                  if (exp_q.size() == 0) begin
                     check("wr_unexpected", m_address, 64'hFFFF_FFFF_FFFF_FFFF);
                  end else begin
                     e = exp_q.pop_front();
                     check("wr_addr", m_address, e[63:32]);
                     check("wr_data", m_writedata, e[31:0]);
                  end
                  check("byteenable", m_byteenable, 4'b1111);
                  mem[m_address] = m_writedata;
                  wr_acc++;
               end
            end
         end else begin
            m_waitrequest = 1'b0;
            prev_stall    = 0;
         end
      end
   end

   // driver tasks
   task automatic fill_src(input logic [31:0] s, input int n);
      for (int i = 0; i < n; i++) mem[s + 32'(4 * i)] = $urandom;
   endtask

   task automatic launch(input logic [31:0] s, input logic [31:0] d, input int n,
                         input bit sync, output int sc);
      if (sync) @(negedge clk);
      src_addr   = s;
      dst_addr   = d;
      word_count = 16'(n);
      start      = 1'b1;
      sc         = cyc;
      for (int i = 0; i < n; i++) begin
         exp_rd_q.push_back(s + 32'(4 * i));
         exp_q.push_back({d + 32'(4 * i), rd_word(s + 32'(4 * i))});
      end
      @(negedge clk);
      start = 1'b0;
      if (n != 0) check("busy_after_start", busy, 1'b1);
      else check("no_bus_zero_count", m_read | m_write, 1'b0);
   endtask

   task automatic wait_done(input int sc, input int exp_lat, input int budget, input bit chain);
      bit seen;
      seen = 0;
      for (int k = 0; k < budget; k++) begin
         if (done) begin
            seen = 1;
            break;
         end
         @(negedge clk);
      end
      check("done_seen", seen, 1'b1);
      if (seen) begin
         if (exp_lat >= 0) check("done_latency", 64'(cyc - sc), 64'(exp_lat));
         check("busy_low_at_done", busy, 1'b0);
         check("wr_queue_drained", exp_q.size(), 0);
         check("rd_queue_drained", exp_rd_q.size(), 0);
         if (!chain) begin
            @(negedge clk);
            check("done_one_cycle", done, 1'b0);
         end
      end
   endtask

   task automatic check_copy(input logic [31:0] s, input logic [31:0] d, input int n);
      for (int i = 0; i < n; i++)
         check("dst_mem", rd_word(d + 32'(4 * i)), rd_word(s + 32'(4 * i)));
   endtask

   initial begin : main
      int sc;
      int pulses;
      int cmds;
      bit found;
      reset_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; word_count = '0;
      repeat (3) @(negedge clk);
      check("rst_state", dbg_state, 3'd0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_cmd", {m_read, m_write}, 2'b00);
      check("rst_addr", m_address, 32'h0);
      check("rst_wdata", m_writedata, 32'h0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // basic 4-word copy, no stalls, zero read latency
      max_wait = 0; lat = 0;
      fill_src(32'h0000, 4);
      launch(32'h0000, 32'h1000, 4, 1, sc);
      wait_done(sc, 10, 50, 0);
      check_copy(32'h0000, 32'h1000, 4);

      // zero-length copy
      launch(32'h0040, 32'h1100, 0, 1, sc);
      wait_done(sc, 2, 10, 0);

      // source address wrap
      fill_src(32'hFFFF_FFF8, 2);
      launch(32'hFFFF_FFF8, 32'h2000, 3, 1, sc);
      wait_done(sc, 8, 50, 0);
      check_copy(32'hFFFF_FFF8, 32'h2000, 3);

      // random stalls with delayed read data
      max_wait = 3; lat = 2;
      fill_src(32'h0100, 6);
      launch(32'h0100, 32'h8000, 6, 1, sc);
      wait_done(sc, -1, 200, 0);
      check_copy(32'h0100, 32'h8000, 6);

      // random stalls, zero-latency reads
      lat = 0;
      fill_src(32'h0200, 5);
      launch(32'h0200, 32'h8100, 5, 1, sc);
      wait_done(sc, -1, 200, 0);
      check_copy(32'h0200, 32'h8100, 5);

      // start while busy is ignored
      max_wait = 0;
      fill_src(32'h3000, 5);
      launch(32'h3000, 32'h4000, 5, 1, sc);
      @(negedge clk);
      src_addr = 32'h5000; dst_addr = 32'h6000; word_count = 16'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(sc, 12, 50, 0);
      pulses = 0; cmds = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (done) pulses++;
         if (m_read || m_write) cmds++;
      end
      check("no_extra_done", pulses, 0);
      check("bus_idle_after_copy", cmds, 0);
      check_copy(32'h3000, 32'h4000, 5);

      // back-to-back: new start in the done cycle
      fill_src(32'h0300, 2);
      fill_src(32'h0400, 1);
      launch(32'h0300, 32'hB000, 2, 1, sc);
      wait_done(sc, 6, 50, 1);
      launch(32'h0400, 32'hB100, 1, 0, sc);
      wait_done(sc, 4, 50, 0);
      check_copy(32'h0400, 32'hB100, 1);

      // reset during the third write
      fill_src(32'h9000, 5);
      wr_acc = 0;
      launch(32'h9000, 32'hA000, 5, 1, sc);
      found = 0;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk);
         #2;
         if (m_write && wr_acc == 2) begin
            found = 1;
            break;
         end
      end
      check("third_write_seen", found, 1'b1);
      reset_n = 1'b0;
      #1;
      check("abort_state", dbg_state, 3'd0);
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_cmd", {m_read, m_write}, 2'b00);
      check("abort_addr", m_address, 32'h0);
      check("abort_wdata", m_writedata, 32'h0);
      exp_q.delete();
      exp_rd_q.delete();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      cmds = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (m_read || m_write || busy) cmds++;
      end
      check("idle_after_abort", cmds, 0);
      fill_src(32'h9100, 2);
      launch(32'h9100, 32'hA100, 2, 1, sc);
      wait_done(sc, 6, 50, 0);
      check_copy(32'h9100, 32'hA100, 2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
